// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : bus_arbiter
//  Description : Two-cache main-memory bus arbiter. Alternates ownership on
//                contention, drives the memory request and snoop lines for
//                the owner, waits for data ready with a bounded timeout and
//                returns read data together with done / error pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter #(
    parameter int TIMEOUT = 15
) (
    input  logic        SCLK,
    input  logic        SRST,
    input  logic        req_A,
    input  logic        req_B,
    input  logic        cpu_rw_A,
    input  logic        cpu_rw_B,
    input  logic [23:0] addr_A,
    input  logic [23:0] addr_B,
    input  logic [31:0] wdata_A,
    input  logic [31:0] wdata_B,
    input  logic        DR,
    input  logic [31:0] mem_data,
    output logic        AR,
    output logic        RW_A,
    output logic        RW_B,
    output logic        snoop_A,
    output logic        snoop_B,
    output logic [23:0] addr_o,
    output logic [31:0] data_o,
    output logic        gnt_A,
    output logic        gnt_B,
    output logic        done_A,
    output logic        done_B,
    output logic        err_A,
    output logic        err_B,
    output logic [31:0] rdata
);

    localparam logic [3:0] c_timeout_cnt = 4'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t      state_q;
    logic        owner_b_q;   // 1 = cache B owns the bus
    logic        last_b_q;    // 1 = cache B was served last
    logic        rw_q;
    logic [3:0]  cnt_q;
    logic [23:0] addr_q;
    logic [31:0] data_q;
    logic [31:0] rdata_q;
    logic        ar_q;
    logic        rw_a_q;
    logic        rw_b_q;
    logic        snoop_a_q;
    logic        snoop_b_q;
    logic        gnt_a_q;
    logic        gnt_b_q;
    logic        done_a_q;
    logic        done_b_q;
    logic        err_a_q;
    logic        err_b_q;

    logic        owner_b_d;
    logic [3:0]  cnt_d;

    // Arbitration winner: sole requester, or the side not served last on a tie
    always_comb begin
        owner_b_d = req_B;
        if (req_A && req_B) begin
            owner_b_d = ~last_b_q;
        end
        cnt_d = cnt_q + 4'd1;
    end

    // Arbiter FSM with all outputs registered
    always_ff @(posedge SCLK or posedge SRST) begin
        if (SRST) begin
            state_q   <= ST_IDLE;
            owner_b_q <= 1'b0;
            last_b_q  <= 1'b1;
            rw_q      <= 1'b0;
            cnt_q     <= 4'd0;
            addr_q    <= 24'd0;
            data_q    <= 32'd0;
            rdata_q   <= 32'd0;
            ar_q      <= 1'b0;
            rw_a_q    <= 1'b0;
            rw_b_q    <= 1'b0;
            snoop_a_q <= 1'b0;
            snoop_b_q <= 1'b0;
            gnt_a_q   <= 1'b0;
            gnt_b_q   <= 1'b0;
            done_a_q  <= 1'b0;
            done_b_q  <= 1'b0;
            err_a_q   <= 1'b0;
            err_b_q   <= 1'b0;
        end else begin
            // completion flags are single-cycle pulses
            done_a_q <= 1'b0;
            done_b_q <= 1'b0;
            err_a_q  <= 1'b0;
            err_b_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_A || req_B) begin
                        state_q   <= ST_ACCESS;
                        owner_b_q <= owner_b_d;
                        last_b_q  <= owner_b_d;
                        rw_q      <= owner_b_d ? cpu_rw_B : cpu_rw_A;
                        addr_q    <= owner_b_d ? addr_B : addr_A;
                        data_q    <= owner_b_d ? wdata_B : wdata_A;
                        ar_q      <= 1'b1;
                        gnt_a_q   <= ~owner_b_d;
                        gnt_b_q   <= owner_b_d;
                        rw_a_q    <= ~owner_b_d & cpu_rw_A;
                        rw_b_q    <= owner_b_d & cpu_rw_B;
                        snoop_a_q <= owner_b_d;
                        snoop_b_q <= ~owner_b_d;
                    end
                end
                ST_ACCESS: begin
                    // DR is deliberately ignored here: it may still be high
                    // from the previous access
                    state_q <= ST_WAIT;
                    cnt_q   <= 4'd0;
                end
                ST_WAIT: begin
                    if (DR || (cnt_d == c_timeout_cnt)) begin
                        state_q   <= ST_DONE;
                        ar_q      <= 1'b0;
                        rw_a_q    <= 1'b0;
                        rw_b_q    <= 1'b0;
                        snoop_a_q <= 1'b0;
                        snoop_b_q <= 1'b0;
                        done_a_q  <= ~owner_b_q;
                        done_b_q  <= owner_b_q;
                        if (DR) begin
                            if (rw_q) begin
                                rdata_q <= mem_data;
                            end
                        end else begin
                            cnt_q   <= cnt_d;
                            err_a_q <= ~owner_b_q;
                            err_b_q <= owner_b_q;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    gnt_a_q <= 1'b0;
                    gnt_b_q <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign AR      = ar_q;
    assign RW_A    = rw_a_q;
    assign RW_B    = rw_b_q;
    assign snoop_A = snoop_a_q;
    assign snoop_B = snoop_b_q;
    assign addr_o  = addr_q;
    assign data_o  = data_q;
    assign gnt_A   = gnt_a_q;
    assign gnt_B   = gnt_b_q;
    assign done_A  = done_a_q;
    assign done_B  = done_b_q;
    assign err_A   = err_a_q;
    assign err_B   = err_b_q;
    assign rdata   = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_arbiter
//  Description : Scoreboard bench for bus_arbiter. A transaction-level model
//                predicts winner, completion cycle, error and read data; a
//                monitor compares the bus outputs every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;

    localparam int TIMEOUT = 15;

    logic        SCLK = 1'b0;
    logic        SRST = 1'b1;
    logic        req_A = 1'b0, req_B = 1'b0;
    logic        cpu_rw_A = 1'b0, cpu_rw_B = 1'b0;
    logic [23:0] addr_A = '0, addr_B = '0;
    logic [31:0] wdata_A = '0, wdata_B = '0;
    logic        DR = 1'b0;
    logic [31:0] mem_data = '0;
    logic        AR, RW_A, RW_B, snoop_A, snoop_B;
    logic [23:0] addr_o;
    logic [31:0] data_o;
    logic        gnt_A, gnt_B, done_A, done_B, err_A, err_B;
    logic [31:0] rdata;

    bus_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .SCLK(SCLK), .SRST(SRST),
        .req_A(req_A), .req_B(req_B),
        .cpu_rw_A(cpu_rw_A), .cpu_rw_B(cpu_rw_B),
        .addr_A(addr_A), .addr_B(addr_B),
        .wdata_A(wdata_A), .wdata_B(wdata_B),
        .DR(DR), .mem_data(mem_data),
        .AR(AR), .RW_A(RW_A), .RW_B(RW_B),
        .snoop_A(snoop_A), .snoop_B(snoop_B),
        .addr_o(addr_o), .data_o(data_o),
        .gnt_A(gnt_A), .gnt_B(gnt_B),
        .done_A(done_A), .done_B(done_B),
        .err_A(err_A), .err_B(err_B),
        .rdata(rdata)
    );

    always #5 SCLK = ~SCLK;

    // {AR, gnt_A, gnt_B, RW_A, RW_B, snoop_A, snoop_B, done_A, done_B, err_A, err_B}
    logic [10:0] w_vec;
    assign w_vec = {AR, gnt_A, gnt_B, RW_A, RW_B, snoop_A, snoop_B,
                    done_A, done_B, err_A, err_B};
    localparam logic [10:0] c_done_mask = 11'b111_0000_1111;

    typedef struct {
        bit          is_b;
        bit          rw;
        bit          err;
        logic [23:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          s;      // edge at which arbitration happens
        int          d;      // edges from arbitration to the done pulse
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    bit          mon_off = 1'b1;
    bit          last_b = 1'b1;        // model: side served last
    logic [31:0] rd_model = '0;        // model: rdata contents

    always @(posedge SCLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: expected bus state derived from the head transaction
    always @(negedge SCLK) begin
        if (!mon_off && !SRST) begin
            if (q.size() == 0 || (cyc - q[0].s) < 0) begin
                chk("idle_bus", 32'(w_vec), 32'd0);
            end else begin
                exp_t h;
                int   o;
                h = q[0];
                o = cyc - h.s;
                if (o < h.d) begin
                    chk("active_bus", 32'(w_vec),
                        32'({1'b1, !h.is_b, h.is_b, !h.is_b & h.rw, h.is_b & h.rw,
                             h.is_b, !h.is_b, 4'b0000}));
                end else begin
                    chk("done_bus", 32'(w_vec & c_done_mask),
                        32'({1'b0, !h.is_b, h.is_b, 4'b0000, !h.is_b, h.is_b,
                             !h.is_b & h.err, h.is_b & h.err}));
                    chk("addr_o", 32'(addr_o), 32'(h.addr));
                    chk("data_o", data_o, h.wdata);
                    chk("rdata", rdata, h.rdata);
                    void'(q.pop_front());
                end
            end
        end
    end

    // One transaction, started at a negedge while the DUT is idle; returns at
    // the negedge of the following idle cycle
    task automatic do_txn(input bit ra, input bit rb, input bit rwa, input bit rwb,
                          input logic [23:0] aa, input logic [23:0] ab,
                          input logic [31:0] wa, input logic [31:0] wb,
                          input int dly, input bit drop, input bit stale,
                          input logic [31:0] mem);
        exp_t e;
        int   dd;
        dd     = stale ? 0 : dly;
        e.is_b = (ra && rb) ? !last_b : rb;
        last_b = e.is_b;
        e.rw    = e.is_b ? rwb : rwa;
        e.addr  = e.is_b ? ab : aa;
        e.wdata = e.is_b ? wb : wa;
        e.err   = (dd >= TIMEOUT);
        if (e.rw && !e.err) rd_model = mem;
        e.rdata = rd_model;
        e.s     = cyc + 1;
        e.d     = 2 + ((dd < TIMEOUT) ? dd : TIMEOUT - 1);
        q.push_back(e);

        req_A = ra; req_B = rb; cpu_rw_A = rwa; cpu_rw_B = rwb;
        addr_A = aa; addr_B = ab; wdata_A = wa; wdata_B = wb;
        DR = stale;
        @(posedge SCLK); @(negedge SCLK);               // ACCESS
        if (drop) begin req_A = 1'b0; req_B = 1'b0; end
        DR = stale ? 1'b1 : 1'($urandom_range(0, 1));
        mem_data = $urandom;
        for (int k = 0; k < TIMEOUT; k++) begin
            @(posedge SCLK); @(negedge SCLK);           // WAIT cycle k
            DR = (k == dd);
            mem_data = (k == dd) ? mem : $urandom;
            if (k == dd) break;
        end
        @(posedge SCLK); @(negedge SCLK);               // DONE
        DR = stale;
        @(posedge SCLK); @(negedge SCLK);               // IDLE
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dly;
        bit ra, rb;
        // reset state
        repeat (3) @(negedge SCLK);
        chk("reset_bus", 32'(w_vec), 32'd0);
        chk("reset_rdata", rdata, 32'd0);
        chk("reset_addr_o", 32'(addr_o), 32'd0);
        chk("reset_data_o", data_o, 32'd0);
        SRST = 1'b0;
        mon_off = 1'b0;
        @(negedge SCLK);

        // read by A, data ready on first WAIT cycle
        do_txn(1, 0, 1, 0, 24'h000105, 24'h0, 32'h0, 32'h0, 0, 0, 0, 32'd5);
        // write by B leaves rdata unchanged
        do_txn(0, 1, 0, 0, 24'h0, 24'h00AB07, 32'h0, 32'hDEADBEEF, 1, 0, 0, 32'h1234);
        // both held for four transactions: A,B,A,B
        for (int i = 0; i < 4; i++)
            do_txn(1, 1, 1, 1, 24'h000100 + 24'(i), 24'h000200 + 24'(i),
                   32'(i), 32'(i + 16), i, 0, 0, 32'hA000 + 32'(i));
        // timeout
        do_txn(1, 0, 1, 0, 24'h123456, 24'h0, 32'h0, 32'h0, TIMEOUT, 0, 0, 32'hBAD);
        // DR stuck high across transactions
        do_txn(1, 0, 1, 0, 24'h000001, 24'h0, 32'h0, 32'h0, 0, 0, 1, 32'h77);
        do_txn(0, 1, 1, 1, 24'h0, 24'h000002, 32'h0, 32'h0, 0, 0, 1, 32'h88);
        DR = 1'b0;

        // randomized traffic
        for (int i = 0; i < 200; i++) begin
            ra = 1'($urandom_range(0, 1));
            rb = 1'($urandom_range(0, 1));
            if (!ra && !rb) ra = 1'b1;
            dly = ($urandom_range(0, 7) == 0) ? int'($urandom_range(TIMEOUT - 1, TIMEOUT + 2))
                                              : int'($urandom_range(0, 3));
            do_txn(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   24'($urandom), 24'($urandom), $urandom, $urandom, dly,
                   ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0), $urandom);
        end
        DR = 1'b0;

        // asynchronous reset in the middle of WAIT
        mon_off = 1'b1;
        req_A = 1'b1; req_B = 1'b0; cpu_rw_A = 1'b1;
        @(posedge SCLK); @(negedge SCLK);
        req_A = 1'b0;
        @(posedge SCLK); @(negedge SCLK);
        chk("pre_reset_ar", 32'(AR), 32'd1);
        #2 SRST = 1'b1;
        #1;
        chk("async_reset_bus", 32'(w_vec), 32'd0);
        chk("async_reset_rdata", rdata, 32'd0);
        chk("async_reset_addr_o", 32'(addr_o), 32'd0);
        @(posedge SCLK); @(negedge SCLK);
        chk("held_reset_bus", 32'(w_vec), 32'd0);
        SRST = 1'b0;
        last_b = 1'b1;
        rd_model = '0;
        q.delete();
        mon_off = 1'b0;
        @(negedge SCLK);
        // first tie after reset goes to A, then B
        do_txn(1, 1, 1, 1, 24'h00AAAA, 24'h00BBBB, 32'h1, 32'h2, 0, 0, 0, 32'hC0DE);
        do_txn(1, 1, 0, 0, 24'h00AAAA, 24'h00BBBB, 32'h1, 32'h2, 2, 0, 0, 32'hC0DF);
        req_A = 1'b0; req_B = 1'b0;
        repeat (3) @(negedge SCLK);
        chk("scoreboard_empty", 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 15, meaning WAIT cycles allowed for DR (legal 1..15).
REQ-002 The block SHALL have port SCLK, input, 1, meaning single system clock, rising-edge active.
REQ-003 The block SHALL have port SRST, input, 1, meaning reset, asynchronous and active-high.
REQ-004 The block SHALL have ports req_A / req_B, input, 1 each, meaning cache A / B requests a main-memory access.
REQ-005 The block SHALL have ports cpu_rw_A / cpu_rw_B, input, 1 each, meaning 1 = read and 0 = write.
REQ-006 The block SHALL have ports addr_A / addr_B, input, 24 each, meaning access address (tag = [23:8], line = [7:0]).
REQ-007 The block SHALL have ports wdata_A / wdata_B, input, 32 each, meaning write data.
REQ-008 The block SHALL have port DR, input, 1, meaning main-memory data ready.
REQ-009 The block SHALL have port mem_data, input, 32, meaning main-memory read data.
REQ-010 The block SHALL have port AR, output, 1, meaning access request to main memory.
REQ-011 The block SHALL have ports RW_A / RW_B, output, 1 each, meaning owner's read/write to main memory.
REQ-012 The block SHALL have ports snoop_A / snoop_B, output, 1 each, meaning the cache observes the other's bus cycle.
REQ-013 The block SHALL have ports addr_o, output, 24 and data_o, output, 32, meaning latched address and write data.
REQ-014 The block SHALL have ports gnt_A / gnt_B, done_A / done_B and err_A / err_B, output, 1 each.
REQ-015 The block SHALL have port rdata, output, 32, meaning read data returned to the owner.

Function
REQ-016 The FSM SHALL have states IDLE, ACCESS, WAIT and DONE; all outputs SHALL be registered.
REQ-017 IDLE, one requester: at the next edge that requester SHALL win, ACCESS is entered and its rw/addr/wdata latched.
REQ-018 IDLE, both requesting: the side not equal to last_served SHALL win, and last_served SHALL update to the winner.
REQ-019 ACCESS/WAIT with owner A: AR=1, RW_A=latched rw, snoop_B=1 and RW_B=snoop_A=0; owner B mirrors this.
REQ-020 When not owner, RW_x and snoop_x SHALL be 0; with no owner, AR=0.
REQ-021 gnt_x SHALL be 1 from entry to ACCESS through DONE, and 0 otherwise.
REQ-022 ACCESS SHALL last exactly one cycle with DR ignored (stale-DR protection), then go to WAIT.
REQ-023 WAIT with DR=1 SHALL go to DONE; on a read, rdata SHALL capture mem_data at that edge.
REQ-024 WAIT SHALL clear a 4-bit counter on entry and increment it each cycle without DR.
REQ-025 When the counter reaches TIMEOUT, the FSM SHALL go to DONE with err_x=1 and rdata unchanged.
REQ-026 DONE SHALL last one cycle: AR=0, done_x=1 (err_x as set), then go to IDLE.
REQ-027 done_x and err_x SHALL each be single-cycle pulses.
REQ-028 A drop of req_x after grant SHALL be ignored; the transaction always completes.
REQ-029 A request held high in IDLE after DONE SHALL be a new request arbitrated per REQ-018.
REQ-030 Latency from req sampled in IDLE to done_x SHALL be 3 edges with DR=1 on the first WAIT cycle.
REQ-031 A write SHALL leave rdata unchanged.
REQ-032 A requester SHALL never be granted twice in a row while the other is continuously requesting.

Reset
REQ-033 SRST=1 SHALL immediately (asynchronously) force IDLE, and all outputs, counter and rdata to 0, with last_served=B.
REQ-034 Reset mid-transaction SHALL abort without a done or err pulse; after release, A wins the first tie.

Verification
REQ-035 Reset, then req_A=1, cpu_rw_A=1, addr_A=0x000105, DR=1 on the WAIT cycle, mem_data=5 -> AR for 2 cycles, RW_A=1, snoop_B=1, done_A pulse at edge 3, rdata=5.
REQ-036 req_B write, addr_B=0x00AB07, wdata_B=0xDEADBEEF -> addr_o=0x00AB07, data_o=0xDEADBEEF, RW_B=0, snoop_A=1, done_B pulse, rdata unchanged.
REQ-037 req_A=req_B=1 held for 4 transactions -> grant order A,B,A,B.
REQ-038 DR held 0 -> err_A and done_A pulse together after 15 WAIT cycles, AR then 0.
REQ-039 DR stuck 1 from a previous access -> ACCESS still lasts one cycle and completion takes no fewer than 3 edges.
REQ-040 SRST pulse during WAIT -> all outputs 0 immediately, no done pulse; next tie grants A.
